// File: rtl/jtpang_objdma_pkg.sv
// Shared types and sizes for the object-table DMA.
package jtpang_objdma_pkg;

  localparam int OBJ_LEN = 512;
  localparam int OBJ_AW  = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_XFER  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_WREL  = 3'd4
  } dma_st_e;

endpackage

// File: rtl/jtpang_objdma_ram.sv
// Simple dual-port RAM: port 0 writes, port 1 reads with one-clk latency.
// A same-address read during a write returns the old contents.
module jtframe_dual_ram #(
  parameter int dw = 8,
  parameter int aw = 10
) (
  input  logic          clk,
  input  logic          we0,
  input  logic [aw-1:0] addr0,
  input  logic [dw-1:0] data0,
  input  logic [aw-1:0] addr1,
  output logic [dw-1:0] q1
);

  logic [dw-1:0] mem [0:(1<<aw)-1];

  always_ff @(posedge clk) begin
    if (we0) mem[addr0] <= data0;
  end

  always_ff @(posedge clk) begin
    q1 <= mem[addr1];
  end

endmodule

// File: rtl/jtpang_objdma.sv
// Object-table DMA: on dma_go grabs the CPU bus, copies LEN VRAM bytes into
// the hidden bank of a double-buffered object RAM, then swaps banks.
module jtpang_objdma
  import jtpang_objdma_pkg::*;
#(
  parameter int LEN  = OBJ_LEN,
  parameter bit DBUF = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              dma_go,
  output logic              busrq,
  input  logic              busak_n,
  output logic [OBJ_AW-1:0] dma_addr,
  input  logic [7:0]        vram_dout,
  input  logic [OBJ_AW-1:0] obj_addr,
  output logic [7:0]        obj_data,
  output logic              busy,
  output logic              bank
);

  localparam int                BAW  = DBUF ? OBJ_AW + 1 : OBJ_AW;
  localparam logic [OBJ_AW-1:0] LAST = OBJ_AW'(LEN - 1);

  dma_st_e           st, st_nx;
  logic              busrq_nx, busy_nx;
  logic              rd_vld, rd_vld_nx;
  logic [OBJ_AW-1:0] addr_nx, rd_idx, rd_idx_nx;
  logic              wr_bank, flip, step;

  assign step = cen & ~busak_n;

  always_comb begin
    st_nx     = st;
    busrq_nx  = busrq;
    busy_nx   = busy;
    addr_nx   = dma_addr;
    rd_vld_nx = 1'b0;
    rd_idx_nx = rd_idx;
    flip      = 1'b0;
    case (st)
      ST_IDLE: begin
        if (dma_go) begin
          st_nx    = ST_REQ;
          busrq_nx = 1'b1;
          busy_nx  = 1'b1;
        end
      end
      ST_REQ: begin
        if (!busak_n) begin
          st_nx   = ST_XFER;
          addr_nx = '0;
        end
      end
      ST_XFER: begin
        // A stalled or ungranted cycle issues nothing, so the address simply holds
        if (step) begin
          rd_vld_nx = 1'b1;
          rd_idx_nx = dma_addr;
          addr_nx   = dma_addr + 1'b1;
          if (dma_addr == LAST) begin
            st_nx   = ST_FLUSH;
            addr_nx = '0;
          end
        end
      end
      ST_FLUSH: begin
        st_nx    = ST_WREL;
        busrq_nx = 1'b0;
        flip     = DBUF;
      end
      ST_WREL: begin
        if (busak_n) begin
          st_nx   = ST_IDLE;
          busy_nx = 1'b0;
        end
      end
      default: begin
        st_nx    = ST_IDLE;
        busrq_nx = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= ST_IDLE;
      busrq    <= 1'b0;
      busy     <= 1'b0;
      dma_addr <= '0;
      rd_vld   <= 1'b0;
      rd_idx   <= '0;
      bank     <= 1'b0;
      wr_bank  <= 1'b1;
    end else begin
      st       <= st_nx;
      busrq    <= busrq_nx;
      busy     <= busy_nx;
      dma_addr <= addr_nx;
      rd_vld   <= rd_vld_nx;
      rd_idx   <= rd_idx_nx;
      bank     <= bank ^ flip;
      wr_bank  <= wr_bank ^ flip;
    end
  end

  logic [BAW-1:0] wr_addr, rd_addr;

  generate
    if (DBUF) begin : g_dbuf
      assign wr_addr = {wr_bank, rd_idx};
      assign rd_addr = {~wr_bank, obj_addr};
    end else begin : g_sbuf
      assign wr_addr = rd_idx;
      assign rd_addr = obj_addr;
    end
  endgenerate

  jtframe_dual_ram #(.dw(8), .aw(BAW)) u_buf (
    .clk   (clk),
    .we0   (rd_vld),
    .addr0 (wr_addr),
    .data0 (vram_dout),
    .addr1 (rd_addr),
    .q1    (obj_data)
  );

endmodule

// File: tb/tb_jtpang_objdma.sv
// Directed bench for jtpang_objdma: grant handshake, pause, slow cen,
// ignored starts, mid-transfer reset and bank isolation.
module tb_jtpang_objdma;

  logic       clk = 1'b0, rst_n = 1'b0, cen = 1'b0, dma_go = 1'b0, busak_n = 1'b1;
  logic       busrq, busy, bank;
  logic [8:0] dma_addr, obj_addr = 9'd0;
  logic [7:0] vram_dout, obj_data;

  int checks = 0, failures = 0;
  logic [7:0] key = 8'h5A;
  int cen_div = 1, cyc = 0;
  int n_issue = 0, n_bad_seq = 0;
  logic [8:0] last_addr = 9'd0;
  logic exp_bank = 1'b0;
  logic iso_on = 1'b0;
  logic [7:0] iso_key = 8'h00;
  logic [8:0] iso_raddr;
  int iso_err = 0, iso_n = 0;
  int span;
  bit aborted;

  always #5 clk = ~clk;

  jtpang_objdma dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .dma_go(dma_go), .busrq(busrq),
    .busak_n(busak_n), .dma_addr(dma_addr), .vram_dout(vram_dout),
    .obj_addr(obj_addr), .obj_data(obj_data), .busy(busy), .bank(bank)
  );

  // VRAM model: synchronous read, data one clk after the address
  always @(posedge clk) vram_dout <= dma_addr[7:0] ^ key;

  // cen generator and issued-read monitor
  always @(negedge clk) begin
    cyc++;
    cen = ((cyc % cen_div) == 0);
    if (dma_addr != last_addr) begin
      n_issue++;
      if (dma_addr != last_addr + 9'd1) n_bad_seq++;
      last_addr = dma_addr;
    end
  end

  // Renderer that keeps reading the visible bank
  always @(posedge clk) begin
    if (iso_on) begin
      iso_raddr = obj_addr;
      #2;
      iso_n++;
      if (obj_data !== (iso_raddr[7:0] ^ iso_key)) iso_err++;
      obj_addr = obj_addr + 9'd37;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic verify(input string nm, input logic [7:0] k);
    int errs = 0;
    for (int a = 0; a < 512; a++) begin
      @(negedge clk) obj_addr = 9'(a);
      @(negedge clk);
      if (obj_data !== (8'(a) ^ k)) errs++;
    end
    chk({nm, "_contents"}, errs, 0);
  endtask

  task automatic xfer(input string nm, input logic [7:0] k, input int div, input int pause_at,
                      input bit go_mid, input int rst_at, input bit iso,
                      output int sp, output bit abrt);
    bit done = 0, paused = 0, busy_lost = 0;
    int w;
    abrt = 0;
    @(negedge clk);
    key = k; cen_div = div; n_issue = 0; n_bad_seq = 0; last_addr = dma_addr;
    dma_go = 1'b1;
    @(negedge clk) dma_go = 1'b0;
    chk({nm, "_busrq_on"}, busrq, 1);
    chk({nm, "_busy_on"}, busy, 1);
    repeat (3) @(negedge clk);
    busak_n = 1'b0;
    sp = 0;
    while (!done && sp < 6000) begin
      @(negedge clk);
      sp++;
      dma_go = 1'b0;
      if (!busy) busy_lost = 1;
      if (!busrq) begin
        done = 1;
        if (iso) iso_key = k;
      end else if (pause_at >= 0 && !paused && dma_addr == 9'(pause_at + 1)) begin
        busak_n = 1'b1;
        repeat (7) @(negedge clk);
        chk({nm, "_addr_hold"}, dma_addr, 9'(pause_at + 1));
        busak_n = 1'b0;
        paused = 1;
      end else if (rst_at >= 0 && dma_addr == 9'(rst_at)) begin
        #2 rst_n = 1'b0;
        #1;
        chk({nm, "_rst_busrq"}, busrq, 0);
        chk({nm, "_rst_bank"}, bank, 0);
        @(negedge clk) rst_n = 1'b1;
        busak_n = 1'b1;
        repeat (2) @(negedge clk);
        chk({nm, "_rst_addr"}, dma_addr, 0);
        abrt = 1;
        return;
      end else if (go_mid && dma_addr == 9'd200) begin
        dma_go = 1'b1;
      end
    end
    chk({nm, "_flush"}, done, 1);
    exp_bank = ~exp_bank;
    chk({nm, "_bank"}, bank, exp_bank);
    chk({nm, "_addr_wrap"}, dma_addr, 0);
    if (go_mid) begin
      dma_go = 1'b1;
      @(negedge clk) dma_go = 1'b0;
    end
    @(negedge clk);
    chk({nm, "_busy_wrel"}, busy, 1);
    busak_n = 1'b1;
    w = 0;
    while (busy && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_busy_off"}, busy, 0);
    repeat (3) @(negedge clk);
    chk({nm, "_busrq_idle"}, busrq, 0);
    chk({nm, "_bank_once"}, bank, exp_bank);
    chk({nm, "_n_issue"}, n_issue, 512);
    chk({nm, "_seq"}, n_bad_seq, 0);
    chk({nm, "_busy_held"}, busy_lost, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busrq", busrq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bank", bank, 0);
    chk("rst_addr", dma_addr, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    xfer("t1", 8'h5A, 1, -1, 0, -1, 0, span, aborted);
    verify("t1", 8'h5A);
    @(negedge clk) obj_addr = 9'h1FF;
    repeat (2) @(negedge clk);
    chk("t1_last_byte", obj_data, 8'hA5);

    xfer("t2", 8'h33, 1, 100, 0, -1, 0, span, aborted);
    verify("t2", 8'h33);

    xfer("t3", 8'hC3, 4, -1, 0, -1, 0, span, aborted);
    chk("t3_span", (span >= 2040 && span <= 2056), 1);
    verify("t3", 8'hC3);

    xfer("t4", 8'h0F, 1, -1, 1, -1, 0, span, aborted);
    verify("t4", 8'h0F);

    xfer("t5", 8'h96, 1, -1, 0, 300, 0, span, aborted);
    chk("t5_aborted", aborted, 1);
    exp_bank = 1'b0;
    chk("t5_bank_after_rst", bank, 0);
    verify("t5_hidden", 8'h0F);
    xfer("t5r", 8'h96, 1, -1, 0, -1, 0, span, aborted);
    verify("t5r", 8'h96);

    @(negedge clk);
    iso_key = 8'h96;
    iso_on = 1'b1;
    xfer("t6", 8'h69, 1, -1, 0, -1, 1, span, aborted);
    @(negedge clk) iso_on = 1'b0;
    chk("t6_iso_err", iso_err, 0);
    chk("t6_iso_active", (iso_n > 500), 1);
    verify("t6", 8'h69);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
